vga_timing_monitor: RTL
=======================

// Module: vga_timing_monitor
// PURPOSE
//  Passive receive-side checker for the VGA output (hsync, vsync, rgb, p_tick) of the top-level display pipeline.
//  Samples the stream on pixel ticks and measures line and frame timing against parameters.
//  Locks onto conforming frames and reports a per-frame additive pixel checksum.
//  Used in simulation and as an on-chip self-check.
// PARAMETERS
//  H_DISPLAY   640  active pixels per line
//  H_FP        16   horizontal front porch (ticks)
//  H_SYNC      96   hsync pulse width (ticks)
//  H_BP        48   horizontal back porch (ticks)
//  V_DISPLAY   480  active lines per frame
//  V_FP        10   vertical front porch (lines)
//  V_SYNC      2    vsync pulse width (lines)
//  V_BP        33   vertical back porch (lines)
//  LOCK_FRAMES 2    consecutive good frames required to assert locked
// PORTS
//  clk          in   1   system clock (100 MHz)
//  reset        in   1   synchronous, active-high reset
//  p_tick       in   1   pixel enable; inputs are sampled only when high
//  hsync        in   1   horizontal sync, active low
//  vsync        in   1   vertical sync, active low
//  rgb          in   12  pixel {R[11:8],G[7:4],B[3:0]}
//  locked       out  1   LOCKED state indicator
//  frame_done   out  1   1-clk pulse at each frame end (MEASURE/LOCKED)
//  timing_err   out  1   1-clk pulse, coincident with frame_done, when the frame violated timing
//  frame_sum    out  32  sum of rgb (zero-extended) over the frame's active pixels, mod 2^32
//  pix_count    out  20  active pixels counted in the last frame
//  h_total_meas out  12  last line total in ticks (first mismatching total if any)
//  hsync_width  out  12  last measured hsync width (ticks)
//  v_total_meas out  12  last frame total (lines)
//  vsync_width  out  12  last measured vsync width (lines)
//  err_count    out  8   bad frames, saturating at 255
//  frame_count  out  16  frames completed, wraps
// BEHAVIOUR
//  - Reset: all outputs 0. State SEARCH. Previous-sample sync registers = 0, so no edge is seen until a high-to-low transition is observed.
//  - Sampling: only on clk with p_tick=1. Edges are computed from the current vs previous sampled value.
//  - Output timing: registered outputs update on the clk after the sampling tick.
//  - h_pos (12b): 0 on the hsync-fall tick, +1 per tick.
//    - On hsync rise: width = h_pos; check == H_SYNC.
//    - On the next fall: total = h_pos+1; check == H_SYNC+H_FP+H_BP+H_DISPLAY.
//    - h_valid is set at the first hsync fall after reset.
//  - v_line (12b): 0 on the vsync-fall tick, +1 on each hsync fall.
//    - On vsync rise: width = v_line; check == V_SYNC.
//    - On the next vsync fall: total = v_line+1; check == V sum.
//  - Active pixel: h_pos in [H_SYNC+H_BP, H_SYNC+H_BP+H_DISPLAY-1] and v_line in [V_SYNC+V_BP, V_SYNC+V_BP+V_DISPLAY-1].
//    - Each active tick adds rgb to sum_acc and increments pix_acc.
//  - Frame error: any h/v check failure, h_valid=0, or pix_acc != H_DISPLAY*V_DISPLAY at frame end.
//  - FSM (advances only on the vsync-fall tick):
//    - SEARCH: -> MEASURE. Accumulators cleared. No frame_done.
//    - MEASURE: pulse frame_done and latch outputs.
//      - Good frame: good_cnt+1; when good_cnt reaches LOCK_FRAMES -> LOCKED.
//      - Bad frame: timing_err, err_count+1 (saturating), good_cnt=0.
//    - LOCKED: frame_done. Bad frame -> timing_err, err_count+1, good_cnt=0, -> MEASURE (locked drops the same cycle).
//  - Accumulators clear on every vsync fall.
//  - frame_count increments with each frame_done.
//  - A frame with multiple errors counts once.
//  - Reset mid-frame: immediate return to reset values, regardless of state or p_tick.
// TESTING (scaled params: H 8/2/3/3 -> total 16; V 4/1/2/1 -> total 8; LOCK_FRAMES=2; p_tick every 4th clk)
//  1. Conforming frames, rgb=12'h00F on active pixels.
//     -> 1st vsync fall enters MEASURE, 2nd gives frame_done, 3rd gives locked=1.
//     -> Each frame: frame_sum=0x1E0, pix_count=32, h_total_meas=16, hsync_width=3, v_total_meas=8, vsync_width=2.
//  2. While locked, one line of 17 ticks -> at that frame end: timing_err=1, h_total_meas=17, err_count=1, locked=0.
//     -> Relock after 2 more good frames.
//  3. Random toggling of hsync/vsync/rgb on non-tick clks -> results bit-identical to test 1.
//  4. reset pulsed mid-frame while locked -> next clk: all outputs 0.
//     -> locked returns only at the 3rd vsync fall after release.
//  5. vsync held low 3 lines -> vsync_width=3, timing_err pulse, good_cnt cleared.
//  6. 260 consecutive bad frames -> err_count=255 (saturates); frame_count=260.

Source files
------------

// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: passive VGA stream checker measuring line/frame timing, locking and per-frame pixel checksum
module vga_timing_monitor #(
  parameter int H_DISPLAY   = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_DISPLAY   = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_tick,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [11:0] rgb,
  output logic        locked,
  output logic        frame_done,
  output logic        timing_err,
  output logic [31:0] frame_sum,
  output logic [19:0] pix_count,
  output logic [11:0] h_total_meas,
  output logic [11:0] hsync_width,
  output logic [11:0] v_total_meas,
  output logic [11:0] vsync_width,
  output logic [7:0]  err_count,
  output logic [15:0] frame_count
);
  localparam logic [11:0] H_TOT  = 12'(H_SYNC + H_FP + H_BP + H_DISPLAY);
  localparam logic [11:0] V_TOT  = 12'(V_SYNC + V_FP + V_BP + V_DISPLAY);
  localparam logic [11:0] H_SW   = 12'(H_SYNC);
  localparam logic [11:0] V_SW   = 12'(V_SYNC);
  localparam logic [11:0] H_A0   = 12'(H_SYNC + H_BP);
  localparam logic [11:0] H_A1   = 12'(H_SYNC + H_BP + H_DISPLAY - 1);
  localparam logic [11:0] V_A0   = 12'(V_SYNC + V_BP);
  localparam logic [11:0] V_A1   = 12'(V_SYNC + V_BP + V_DISPLAY - 1);
  localparam logic [19:0] PIX    = 20'(H_DISPLAY * V_DISPLAY);
  localparam logic [7:0]  LOCK_N = 8'(LOCK_FRAMES);
  localparam logic [1:0] SEARCH  = 2'd0;
  localparam logic [1:0] MEASURE = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;
  logic [1:0]  state;
  logic        hs_prev, vs_prev, h_valid, h_mis, err_acc;
  logic [11:0] h_pos, v_line, h_tot_acc, hs_w, vs_w;
  logic [31:0] sum_acc;
  logic [19:0] pix_acc;
  logic [7:0]  good_cnt;
  logic        hs_fall, hs_rise, vs_fall, vs_rise, active, h_tot_bad, frame_bad;
  logic [11:0] h_cur, v_cur, h_tot_now, v_tot_now, h_tot_nx;
  logic [7:0]  good_nx;
  assign locked = state == LOCKED;
  // h_cur/v_cur are the positions of the current tick; totals use the position of the previous tick plus one
  always_comb begin
    hs_fall   = p_tick & hs_prev & ~hsync;
    hs_rise   = p_tick & h_valid & ~hs_prev & hsync;
    vs_fall   = p_tick & vs_prev & ~vsync;
    vs_rise   = p_tick & (state != SEARCH) & ~vs_prev & vsync;
    h_cur     = hs_fall ? 12'd0 : h_pos + 12'd1;
    v_cur     = vs_fall ? 12'd0 : v_line + {11'd0, hs_fall};
    h_tot_now = h_pos + 12'd1;
    v_tot_now = v_line + 12'd1;
    h_tot_bad = hs_fall & h_valid & (h_tot_now != H_TOT);
    h_tot_nx  = (hs_fall & h_valid & ~h_mis) ? h_tot_now : h_tot_acc;
    active    = p_tick & (h_cur >= H_A0) & (h_cur <= H_A1) & (v_cur >= V_A0) & (v_cur <= V_A1);
    frame_bad = err_acc | h_tot_bad | (v_tot_now != V_TOT) | ~h_valid | (pix_acc != PIX);
    good_nx   = good_cnt + 8'd1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= SEARCH;
      hs_prev      <= 1'b0;
      vs_prev      <= 1'b0;
      h_valid      <= 1'b0;
      h_mis        <= 1'b0;
      err_acc      <= 1'b0;
      h_pos        <= '0;
      v_line       <= '0;
      h_tot_acc    <= '0;
      hs_w         <= '0;
      vs_w         <= '0;
      sum_acc      <= '0;
      pix_acc      <= '0;
      good_cnt     <= '0;
      frame_done   <= 1'b0;
      timing_err   <= 1'b0;
      frame_sum    <= '0;
      pix_count    <= '0;
      h_total_meas <= '0;
      hsync_width  <= '0;
      v_total_meas <= '0;
      vsync_width  <= '0;
      err_count    <= '0;
      frame_count  <= '0;
    end else begin
      frame_done <= 1'b0;
      timing_err <= 1'b0;
      if (p_tick) begin
        hs_prev   <= hsync;
        vs_prev   <= vsync;
        h_pos     <= h_cur;
        v_line    <= v_cur;
        h_valid   <= h_valid | hs_fall;
        hs_w      <= hs_rise ? h_cur : hs_w;
        vs_w      <= vs_rise ? v_cur : vs_w;
        sum_acc   <= vs_fall ? 32'd0 : sum_acc + (active ? {20'd0, rgb} : 32'd0);
        pix_acc   <= vs_fall ? 20'd0 : pix_acc + {19'd0, active};
        h_tot_acc <= vs_fall ? 12'd0 : h_tot_nx;
        h_mis     <= ~vs_fall & (h_mis | h_tot_bad);
        err_acc   <= ~vs_fall & (err_acc | h_tot_bad | (hs_rise & (h_cur != H_SW)) | (vs_rise & (v_cur != V_SW)));
        if (vs_fall && state == SEARCH) begin
          state    <= MEASURE;
          good_cnt <= '0;
        end else if (vs_fall) begin
          frame_done   <= 1'b1;
          frame_count  <= frame_count + 16'd1;
          frame_sum    <= sum_acc;
          pix_count    <= pix_acc;
          h_total_meas <= h_tot_nx;
          hsync_width  <= hs_w;
          v_total_meas <= v_tot_now;
          vsync_width  <= vs_w;
          if (frame_bad) begin
            timing_err <= 1'b1;
            err_count  <= err_count + {7'd0, err_count != 8'hFF};
            good_cnt   <= '0;
            state      <= MEASURE;
          end else if (state == MEASURE) begin
            good_cnt <= good_nx;
            state    <= (good_nx >= LOCK_N) ? LOCKED : MEASURE;
          end
        end
      end
    end
  end
endmodule
